// File: rtl/cpsr_flagunit_if.sv
// rtl/cpsr_flagunit_if.sv - EX-stage flag-update bus and flag bus to the condition checker
interface cpsr_flagunit_if #(
  parameter int WIDTH = 32
);
  logic             validin;
  logic             setflagsin;
  logic             shouldexecin;
  logic [1:0]       opin;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] resultin;
  logic             shiftcarryin;
  logic             stallin;
  logic             flushin;
  logic             msrwrin;
  logic [3:0]       msrdatain;
  logic [3:0]       cpsrout;
  logic             pendingout;

  // Pipeline side driving EX-stage activity and observing the flags.
  modport master (
    output validin, setflagsin, shouldexecin, opin, ain, bin, resultin,
           shiftcarryin, stallin, flushin, msrwrin, msrdatain,
    input  cpsrout, pendingout
  );

  // Flag unit side.
  modport slave (
    input  validin, setflagsin, shouldexecin, opin, ain, bin, resultin,
           shiftcarryin, stallin, flushin, msrwrin, msrdatain,
    output cpsrout, pendingout
  );
endinterface

// File: rtl/cpsr_flagunit.sv
// rtl/cpsr_flagunit.sv - NZCV producer and CPSR flag register; CPSR_FLAG_BYPASS_EN forwards stage 1 to cpsrout
module cpsr_flagunit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           nreset,
  cpsr_flagunit_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  // Flag encoding: bit0 Z, bit1 C, bit2 N, bit3 V.
  logic [3:0] flagreg;
  logic [3:0] flagsq;
  logic       wrq;
  logic [3:0] newflags;
  logic       cap;
  logic       cur_v;

  assign cap = bus.validin & bus.setflagsin & bus.shouldexecin &
               (bus.opin != 2'b11) & ~bus.flushin & ~bus.stallin;

`ifdef CPSR_FLAG_BYPASS_EN
  logic [3:0] fwd;
  assign fwd            = wrq ? flagsq : flagreg;
  assign cur_v          = fwd[3];
  assign bus.cpsrout    = fwd;
  assign bus.pendingout = 1'b0;
`else
  assign cur_v          = flagreg[3];
  assign bus.cpsrout    = flagreg;
  assign bus.pendingout = wrq;
`endif

  // EX-stage flag computation; ADD carry uses a > ~b to avoid a wide adder.
  always_comb begin
    newflags    = 4'b0000;
    newflags[2] = bus.resultin[MSB];
    newflags[0] = (bus.resultin == '0);
    case (bus.opin)
      2'b00: begin
        newflags[1] = (bus.ain > ~bus.bin);
        newflags[3] = (bus.ain[MSB] == bus.bin[MSB]) &
                      (bus.resultin[MSB] != bus.ain[MSB]);
      end
      2'b01: begin
        newflags[1] = (bus.ain >= bus.bin);
        newflags[3] = (bus.ain[MSB] != bus.bin[MSB]) &
                      (bus.resultin[MSB] != bus.ain[MSB]);
      end
      2'b10: begin
        newflags[1] = bus.shiftcarryin;
        newflags[3] = cur_v;
      end
      default: begin
        newflags[1] = 1'b0;
        newflags[3] = 1'b0;
      end
    endcase
  end

  // Stage 1: capture a setter, drain when not stalled, drop on MSR unless a new capture arrives.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wrq    <= 1'b0;
      flagsq <= 4'b0000;
    end else if (cap) begin
      wrq    <= 1'b1;
      flagsq <= newflags;
    end else if (bus.msrwrin || !bus.stallin) begin
      wrq    <= 1'b0;
    end
  end

  // Architectural flag register: MSR write has priority over the stage-1 commit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      flagreg <= 4'b0000;
    end else if (bus.msrwrin) begin
      flagreg <= bus.msrdatain;
    end else if (wrq && !bus.stallin) begin
      flagreg <= flagsq;
    end
  end
endmodule

// File: tb/tb_cpsr_flagunit.sv
// tb/tb_cpsr_flagunit.sv - scoreboard bench for cpsr_flagunit with directed vectors
module tb_cpsr_flagunit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  cpsr_flagunit_if #(.WIDTH(WIDTH)) bus ();

  cpsr_flagunit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] cpsr;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event sample_now;

  task automatic idle();
    bus.validin      = 1'b0;
    bus.setflagsin   = 1'b0;
    bus.shouldexecin = 1'b0;
    bus.opin         = 2'b11;
    bus.ain          = '0;
    bus.bin          = '0;
    bus.resultin     = '0;
    bus.shiftcarryin = 1'b0;
    bus.stallin      = 1'b0;
    bus.flushin      = 1'b0;
    bus.msrwrin      = 1'b0;
    bus.msrdatain    = 4'b0000;
  endtask

  task automatic op(input logic v, input logic s, input logic e, input logic [1:0] o,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                    input logic sc);
    bus.validin      = v;
    bus.setflagsin   = s;
    bus.shouldexecin = e;
    bus.opin         = o;
    bus.ain          = a;
    bus.bin          = b;
    bus.resultin     = r;
    bus.shiftcarryin = sc;
  endtask

  function automatic exp_t mk(input string name, input logic [3:0] c_nb, input logic p_nb,
                              input logic [3:0] c_b);
    exp_t e;
    e.name = name;
`ifdef CPSR_FLAG_BYPASS_EN
    e.cpsr = c_b;
    e.pend = 1'b0;
`else
    e.cpsr = c_nb;
    e.pend = p_nb;
`endif
    return e;
  endfunction

  // Advance one edge and record what the outputs must show in the following cycle.
  task automatic tick(input string name, input logic [3:0] c_nb, input logic p_nb,
                      input logic [3:0] c_b);
    @(posedge clk);
    #1;
    q.push_back(mk(name, c_nb, p_nb, c_b));
  endtask

  // Monitor: samples mid-cycle, or immediately when the stimulus requests it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.cpsrout !== e.cpsr || bus.pendingout !== e.pend) begin
          n_fail++;
          $display("FAIL %s: cpsrout=%b pendingout=%b, expected cpsrout=%b pendingout=%b",
                   e.name, bus.cpsrout, bus.pendingout, e.cpsr, e.pend);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 nreset = 1'b1;
    tick("reset_state", 4'b0000, 1'b0, 4'b0000);

    // ADD FFFFFFFF+1=0 -> Z,C
    op(1, 1, 1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick("add_pending", 4'b0000, 1'b1, 4'b0011);
    idle();
    tick("add_commit", 4'b0011, 1'b0, 4'b0011);

    // SUB 80000000-1 -> V,C
    op(1, 1, 1, 2'b01, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0);
    tick("sub_pending", 4'b0011, 1'b1, 4'b1010);
    idle();
    tick("sub_commit", 4'b1010, 1'b0, 4'b1010);

    // LOGIC result negative, shifter carry 0, V preserved
    op(1, 1, 1, 2'b10, 32'h0, 32'h0, 32'h8000_0000, 0);
    tick("logic_pending", 4'b1010, 1'b1, 4'b1100);
    idle();
    tick("logic_commit", 4'b1100, 1'b0, 4'b1100);

    // Non-capturing instructions
    op(1, 1, 0, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick("cond_fail", 4'b1100, 1'b0, 4'b1100);
    op(1, 0, 1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick("no_sbit", 4'b1100, 1'b0, 4'b1100);
    op(1, 1, 1, 2'b11, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick("op_none", 4'b1100, 1'b0, 4'b1100);
    idle();
    tick("idle_hold", 4'b1100, 1'b0, 4'b1100);

    // ADD 1+2=3 -> 0000, then stall three cycles
    op(1, 1, 1, 2'b00, 32'h1, 32'h2, 32'h3, 0);
    tick("stall_capture", 4'b1100, 1'b1, 4'b0000);
    idle();
    bus.stallin = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall_hold", 4'b1100, 1'b1, 4'b0000);
    bus.stallin = 1'b0;
    tick("stall_release", 4'b0000, 1'b0, 4'b0000);

    // Stage 1 holds 0100, MSR writes 1001 and wins
    op(1, 1, 1, 2'b10, 32'h0, 32'h0, 32'h8000_0000, 0);
    tick("msr_pre_capture", 4'b0000, 1'b1, 4'b0100);
    idle();
    bus.msrwrin   = 1'b1;
    bus.msrdatain = 4'b1001;
    tick("msr_write", 4'b1001, 1'b0, 4'b1001);
    idle();
    tick("msr_no_stale", 4'b1001, 1'b0, 4'b1001);

    // Flushed setter is not captured
    op(1, 1, 1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    bus.flushin = 1'b1;
    tick("flush_nocap", 4'b1001, 1'b0, 4'b1001);
    idle();
    tick("flush_after", 4'b1001, 1'b0, 4'b1001);

    // MSR and capture in the same cycle: MSR first, then the capture commits
    op(1, 1, 1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    bus.msrwrin   = 1'b1;
    bus.msrdatain = 4'b0000;
    tick("msr_and_cap", 4'b0000, 1'b1, 4'b0011);
    idle();
    tick("msr_and_cap_commit", 4'b0011, 1'b0, 4'b0011);

    // Back-to-back setters: SUB 5-3 -> C; ADD FFFFFFFF+FFFFFFFF -> N,C
    op(1, 1, 1, 2'b01, 32'h5, 32'h3, 32'h2, 0);
    tick("b2b_first", 4'b0011, 1'b1, 4'b0010);
    op(1, 1, 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    tick("b2b_second", 4'b0010, 1'b1, 4'b0110);
    idle();
    tick("b2b_commit", 4'b0110, 1'b0, 4'b0110);

    // Async reset with an update (0011) in flight
    op(1, 1, 1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick("rst_inflight", 4'b0110, 1'b1, 4'b0011);
    idle();
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    q.push_back(mk("async_reset", 4'b0000, 1'b0, 4'b0000));
    -> sample_now;
    @(posedge clk);
    @(negedge clk);
    #1 nreset = 1'b1;
    tick("post_reset_1", 4'b0000, 1'b0, 4'b0000);
    tick("post_reset_2", 4'b0000, 1'b0, 4'b0000);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpsr_flagunit.md
Name: cpsr_flagunit

Overview:
- Producer side of the condition-flag interface: computes NZCV from EX-stage ALU activity, pipelines the update and commits it to the architectural CPSR flag register.
- Drives the 4-bit flag bus consumed by the condition checker.
- Encoding, fixed for the whole design: bit0 Z, bit1 C, bit2 N, bit3 V.
- Also provides a direct flag-write port for MSR-style instructions and a pending indication for hazard/stall logic.

Parameters:
- WIDTH, 32, datapath width of ain/bin/resultin; N is taken from bit WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- validin  input  1  EX-stage instruction valid.
- setflagsin  input  1  instruction S bit.
- shouldexecin  input  1  condition-pass from the condition checker.
- opin  input  2  flag class: 00 ADD, 01 SUB, 10 LOGIC, 11 NONE.
- ain  input  WIDTH  ALU operand A.
- bin  input  WIDTH  ALU operand B, post-shift.
- resultin  input  WIDTH  ALU result.
- shiftcarryin  input  1  shifter carry-out, used by LOGIC.
- stallin  input  1  pipeline stall.
- flushin  input  1  kill the EX-stage instruction of this cycle.
- msrwrin  input  1  direct flag write.
- msrdatain  input  4  direct flag value, NZCV encoding.
- cpsrout  output  4  flag bus to the condition checker.
- pendingout  output  1  a flag update is in flight and not yet visible on cpsrout.

Behaviour:
- Reset (nreset low, asynchronous): flag register=0000, stage-1 valid (wrq)=0, stage-1 flags=0000, cpsrout=0000, pendingout=0.
- Capture condition: cap = validin & setflagsin & shouldexecin & (opin!=11) & ~flushin & ~stallin.
- Flag computation, combinational in EX (cur = current flag register):
  - N = resultin[WIDTH-1].
  - Z = (resultin==0).
  - ADD: C = carry out of the (WIDTH+1)-bit sum ain+bin; V = (ain[msb]==bin[msb]) & (resultin[msb]!=ain[msb]).
  - SUB: C = ~borrow, i.e. 1 iff ain>=bin unsigned; V = (ain[msb]!=bin[msb]) & (resultin[msb]!=ain[msb]).
  - LOGIC: C = shiftcarryin; V = cur V (preserved).
- Stage 1 register:
  - On an edge with cap=1: flagsq <= computed flags, wrq <= 1.
  - Else if stallin=0: wrq <= 0.
  - stallin=1 holds flagsq and wrq unchanged.
- Commit: on an edge with wrq=1 & stallin=0 & msrwrin=0, the flag register <= flagsq.
- Back-to-back setters: the stage-1 commit and the new capture happen on the same edge; no loss.
- MSR path:
  - msrwrin=1 writes msrdatain to the flag register on the next edge, regardless of stallin.
  - It also clears wrq, so the in-flight update is dropped and MSR wins.
  - If cap=1 in the same cycle, the new capture is still taken and commits after the MSR.
- Latency, no bypass: setter in EX at cycle N -> pendingout=1 in cycle N+1 -> new flags on cpsrout in cycle N+2.
- cpsrout is driven directly from the flag register; pendingout = wrq.
- flushin affects only the same-cycle EX instruction; an entry already in stage 1 still commits.
- Non-setting, condition-failed or NONE-class instructions leave all state unchanged, except the normal wrq drain.

Optional Feature:
- Macro: CPSR_FLAG_BYPASS_EN.
- Defined:
  - cpsrout = wrq ? flagsq : flag register, a combinational forward, so the new flags are visible in cycle N+1.
  - pendingout tied to 0.
  - LOGIC V preservation uses the forwarded value.
- Not defined: no forwarding, behaviour exactly as above, pendingout = wrq.

Test Plan:
1. Reset, then ADD with ain=FFFFFFFF, bin=1, resultin=0, S=1, exec=1 -> pendingout=1 in cycle N+1; cpsrout=0011 (Z,C) in cycle N+2 (bypass: cycle N+1).
2. SUB with ain=80000000, bin=1, resultin=7FFFFFFF -> cpsrout=1010 (V,C). Then LOGIC with resultin=80000000, shiftcarryin=0 -> cpsrout=1100 (N, V kept).
3. Setter with shouldexecin=0, then another with setflagsin=0, then opin=11 -> cpsrout and pendingout unchanged throughout.
4. ADD captured, stallin=1 for 3 cycles -> cpsrout held old value and pendingout=1 throughout; commit on the first edge after stallin drops.
5. Stage 1 holds flags 0100 while msrwrin=1, msrdatain=1001 -> cpsrout=1001 and the 0100 update never appears. Separately, flushin with a valid setter -> no capture.
6. Assert nreset low mid-pipeline with wrq=1 -> cpsrout=0000 and pendingout=0 immediately, without waiting for a clock edge; the in-flight update is never committed after release.
